// File: rtl/mem_dados_ctrl_if.sv
// CPU-side request/response and RAM-side port bundle for the load/store sequencer.
interface mem_dados_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 4
);
  localparam int unsigned BYTE_AW = ADDR_WIDTH + 2;

  logic                  req;
  logic                  wr;
  logic [1:0]            dtype;
  logic [BYTE_AW-1:0]    addr;
  logic [31:0]           wdata;
  logic                  ack;
  logic                  err;
  logic [31:0]           rdata;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic                  mem_we;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_q;

  modport master (
    output req, wr, dtype, addr, wdata, mem_q,
    input  ack, err, rdata, busy, mem_raddr, mem_waddr, mem_we, mem_wdata
  );

  modport slave (
    input  req, wr, dtype, addr, wdata, mem_q,
    output ack, err, rdata, busy, mem_raddr, mem_waddr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_dados_ctrl.sv
// Load/store sequencer: byte-addressed CPU requests onto a 32-bit word RAM,
// sub-word stores done as read-modify-write, loads zero-extended.
module mem_dados_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  mem_dados_ctrl_if.slave bus
);
  localparam int unsigned BYTE_AW = ADDR_WIDTH + 2;

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_t;

  state_t               state;
  logic [BYTE_AW-1:0]   a_addr;
  logic                 a_wr;
  logic [1:0]           a_dtype;
  logic [31:0]          a_wdata;
  logic                 a_err;

  logic                 misaligned;
  logic [31:0]          merged;
  logic [31:0]          extracted;
  logic [4:0]           byte_sh;
  logic [4:0]           half_sh;

  // Alignment check on the incoming request (halfword needs addr[0]=0, word addr[1:0]=0).
  always_comb begin
    misaligned = 1'b0;
    case (bus.dtype)
      2'b01:   misaligned = bus.addr[0];
      2'b10:   misaligned = 1'b0;
      default: misaligned = (bus.addr[1:0] != 2'b00);
    endcase
  end

  // Little-endian lane insert (stores) and lane extract (loads) on the RAM word.
  always_comb begin
    byte_sh   = {a_addr[1:0], 3'b000};
    half_sh   = {a_addr[1], 4'b0000};
    merged    = bus.mem_q;
    extracted = bus.mem_q;
    case (a_dtype)
      2'b01: begin
        merged[half_sh +: 16] = a_wdata[15:0];
        extracted             = 32'(bus.mem_q[half_sh +: 16]);
      end
      2'b10: begin
        merged[byte_sh +: 8] = a_wdata[7:0];
        extracted            = 32'(bus.mem_q[byte_sh +: 8]);
      end
      default: begin
        merged    = a_wdata;
        extracted = bus.mem_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_addr        <= '0;
      a_wr          <= 1'b0;
      a_dtype       <= 2'b00;
      a_wdata       <= '0;
      a_err         <= 1'b0;
      bus.ack       <= 1'b0;
      bus.err       <= 1'b0;
      bus.rdata     <= '0;
      bus.busy      <= 1'b0;
      bus.mem_raddr <= '0;
      bus.mem_waddr <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
    end else begin
      bus.ack    <= 1'b0;
      bus.err    <= 1'b0;
      bus.mem_we <= 1'b0;
      case (state)
        IDLE: begin
          bus.busy <= 1'b0;
          if (bus.req) begin
            a_addr   <= bus.addr;
            a_wr     <= bus.wr;
            a_dtype  <= bus.dtype;
            a_wdata  <= bus.wdata;
            a_err    <= misaligned;
            bus.busy <= 1'b1;
            if (misaligned) begin
              state   <= DONE;
              bus.ack <= 1'b1;
              bus.err <= 1'b1;
            end else if (bus.wr && (bus.dtype == 2'b00 || bus.dtype == 2'b11)) begin
              state         <= WRITE;
              bus.mem_we    <= 1'b1;
              bus.mem_waddr <= bus.addr[BYTE_AW-1:2];
              bus.mem_wdata <= bus.wdata;
            end else begin
              state         <= READ;
              bus.mem_raddr <= bus.addr[BYTE_AW-1:2];
            end
          end
        end
        READ: begin
          state <= MERGE;
        end
        MERGE: begin
          if (a_wr) begin
            state         <= WRITE;
            bus.mem_we    <= 1'b1;
            bus.mem_waddr <= a_addr[BYTE_AW-1:2];
            bus.mem_wdata <= merged;
          end else begin
            state     <= DONE;
            bus.rdata <= extracted;
            bus.ack   <= 1'b1;
          end
        end
        WRITE: begin
          state   <= DONE;
          bus.ack <= 1'b1;
        end
        DONE: begin
          // ack/err drop via defaults; busy stays high through this cycle
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.err  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
      if (state == IDLE && bus.req) begin
        bus.err <= misaligned;
      end else if (state != DONE) begin
        bus.err <= (state == MERGE && !a_wr) || state == WRITE ? a_err : 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_dados_ctrl.sv
// Directed bench for mem_dados_ctrl with a behavioural negedge-write / registered-read RAM.
module tb_mem_dados_ctrl;
  logic clk = 1'b0;
  logic rst_n;

  mem_dados_ctrl_if #(.ADDR_WIDTH(4)) bus();

  mem_dados_ctrl #(.ADDR_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:15] = '{default: 32'h0};
  int          we_cnt  = 0;
  int          ack_cnt = 0;
  logic [3:0]  last_waddr = '0;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      ram[bus.mem_waddr] <= bus.mem_wdata;
      we_cnt             <= we_cnt + 1;
      last_waddr         <= bus.mem_waddr;
    end
    if (bus.ack) ack_cnt <= ack_cnt + 1;
  end

  always @(posedge clk) bus.mem_q <= ram[bus.mem_raddr];

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and wait (bounded) for ack; returns edges-to-ack counting E0 as 1.
  task automatic do_txn(input logic w, input logic [1:0] dt, input logic [5:0] a,
                        input logic [31:0] wd, output int lat, output logic e,
                        output logic [31:0] rd, output logic seen);
    @(negedge clk);
    bus.req = 1'b1; bus.wr = w; bus.dtype = dt; bus.addr = a; bus.wdata = wd;
    @(posedge clk); #1;
    lat = 1;
    while (!bus.ack && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    seen = bus.ack;
    e    = bus.err;
    rd   = bus.rdata;
    bus.req = 1'b0;
    @(posedge clk);
  endtask

  int          lat;
  logic        e, seen;
  logic [31:0] rd;
  int          we0, ack0;
  logic [6:0]  ack_vec, busy_vec;
  logic [31:0] rd_first, rd_second;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.req = 1'b0; bus.wr = 1'b0; bus.dtype = 2'b00; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ctl", 32'({bus.ack, bus.err, bus.busy, bus.mem_we}), 32'h0);
    check_eq("rst_rdata", bus.rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: word store then word load
    we0 = we_cnt;
    do_txn(1'b1, 2'b00, 6'h08, 32'hDEADBEEF, lat, e, rd, seen);
    check_eq("t1_st_ack", 32'(seen), 32'h1);
    check_eq("t1_st_lat", 32'(lat), 32'd2);
    check_eq("t1_st_we", 32'(we_cnt - we0), 32'd1);
    check_eq("t1_st_waddr", 32'(last_waddr), 32'd2);
    check_eq("t1_ram2", ram[2], 32'hDEADBEEF);
    do_txn(1'b0, 2'b00, 6'h08, 32'h0, lat, e, rd, seen);
    check_eq("t1_ld_lat", 32'(lat), 32'd3);
    check_eq("t1_ld_rdata", rd, 32'hDEADBEEF);
    check_eq("t1_ld_err", 32'(e), 32'h0);

    // 2: byte store RMW, byte and half loads
    do_txn(1'b1, 2'b10, 6'h09, 32'h00000055, lat, e, rd, seen);
    check_eq("t2_st_lat", 32'(lat), 32'd4);
    check_eq("t2_ram2", ram[2], 32'hDEAD55EF);
    do_txn(1'b0, 2'b10, 6'h0A, 32'h0, lat, e, rd, seen);
    check_eq("t2_ldb", rd, 32'h000000AD);
    do_txn(1'b0, 2'b01, 6'h0A, 32'h0, lat, e, rd, seen);
    check_eq("t2_ldh", rd, 32'h0000DEAD);

    // 3: halfword store into a zero word
    we0 = we_cnt;
    do_txn(1'b1, 2'b01, 6'h0E, 32'h1234ABCD, lat, e, rd, seen);
    check_eq("t3_lat", 32'(lat), 32'd4);
    check_eq("t3_we", 32'(we_cnt - we0), 32'd1);
    check_eq("t3_ram3", ram[3], 32'hABCD0000);
    check_eq("t3_rdata_held", bus.rdata, 32'h0000DEAD);

    // 4: misaligned word load and halfword store
    we0 = we_cnt;
    do_txn(1'b0, 2'b00, 6'h05, 32'h0, lat, e, rd, seen);
    check_eq("t4_ld_lat", 32'(lat), 32'd1);
    check_eq("t4_ld_err", 32'(e), 32'h1);
    check_eq("t4_ld_rdata", rd, 32'h0000DEAD);
    do_txn(1'b1, 2'b01, 6'h03, 32'hFFFFFFFF, lat, e, rd, seen);
    check_eq("t4_st_lat", 32'(lat), 32'd1);
    check_eq("t4_st_err", 32'(e), 32'h1);
    check_eq("t4_we", 32'(we_cnt - we0), 32'd0);
    check_eq("t4_ram0", ram[0], 32'h0);

    // 5: reset while a byte store sits in MERGE
    do_txn(1'b1, 2'b00, 6'h10, 32'h11223344, lat, e, rd, seen);
    check_eq("t5_pre_ram4", ram[4], 32'h11223344);
    we0 = we_cnt; ack0 = ack_cnt;
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b1; bus.dtype = 2'b10; bus.addr = 6'h11; bus.wdata = 32'hAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.req = 1'b0;
    #1;
    check_eq("t5_rst_ctl", 32'({bus.ack, bus.err, bus.busy, bus.mem_we}), 32'h0);
    check_eq("t5_rst_rdata", bus.rdata, 32'h0);
    check_eq("t5_rst_addr", 32'({bus.mem_raddr, bus.mem_waddr}), 32'h0);
    check_eq("t5_rst_wdata", bus.mem_wdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("t5_no_we", 32'(we_cnt - we0), 32'd0);
    check_eq("t5_no_ack", 32'(ack_cnt - ack0), 32'd0);
    do_txn(1'b0, 2'b00, 6'h10, 32'h0, lat, e, rd, seen);
    check_eq("t5_ld", rd, 32'h11223344);

    // 6: back-to-back loads with req held high
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b0; bus.dtype = 2'b00; bus.addr = 6'h08;
    ack_vec = '0; busy_vec = '0; rd_first = '0; rd_second = '0;
    @(posedge clk); #1;
    ack_vec[0] = bus.ack; busy_vec[0] = bus.busy;
    @(negedge clk);
    bus.addr = 6'h0C;
    for (int i = 1; i < 7; i++) begin
      @(posedge clk); #1;
      ack_vec[i]  = bus.ack;
      busy_vec[i] = bus.busy;
      if (i == 2) rd_first = bus.rdata;
      if (i == 6) begin rd_second = bus.rdata; bus.req = 1'b0; end
    end
    @(posedge clk);
    check_eq("t6_ack_seq", 32'(ack_vec), 32'h44);
    check_eq("t6_busy_seq", 32'(busy_vec), 32'h77);
    check_eq("t6_rd1", rd_first, 32'hDEAD55EF);
    check_eq("t6_rd2", rd_second, 32'hABCD0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_dados_ctrl.md
Name: mem_dados_ctrl

Overview:
- Load/store sequencer between the CPU's byte-addressed memory request and the 32-bit word-wide dual-port data RAM.
- Word stores are direct writes. Halfword and byte stores are read-modify-write sequences. Loads are a single read plus lane extraction with zero-extension.
- One transaction in flight at a time, with a req/ack handshake to the CPU.
- `clk` drives both RAM clocks. The RAM writes on negedge and registers its read output on posedge.

Parameters:
- ADDR_WIDTH, 4, RAM word-index width. Byte address width is ADDR_WIDTH+2.

Ports:
- clk  in  1  system clock; also wired to the RAM read and write clocks
- rst_n  in  1  asynchronous active-low reset
- req  in  1  CPU request; addr/wr/dtype/wdata are sampled when req is accepted
- wr  in  1  1 = store, 0 = load
- dtype  in  2  00 word, 01 halfword, 10 byte, 11 word
- addr  in  ADDR_WIDTH+2  byte address
- wdata  in  32  store data; sub-word data is taken from the low bits
- ack  out  1  one-cycle completion pulse
- err  out  1  misaligned access; valid while ack=1
- rdata  out  32  load result; valid while ack=1 and held until the next load completes
- busy  out  1  high in every state except IDLE
- mem_raddr  out  ADDR_WIDTH  RAM read word address
- mem_waddr  out  ADDR_WIDTH  RAM write word address
- mem_we  out  1  RAM write enable
- mem_wdata  out  32  RAM write data
- mem_q  in  32  RAM registered read data

Behaviour:
- **Reset (async, rst_n=0):** state=IDLE; ack, err, mem_we, busy = 0; rdata, mem_wdata, mem_raddr, mem_waddr and internal latches = 0.
  - Reset mid-transaction aborts it. No write occurs if reset is asserted before the WRITE-cycle negedge. No ack is issued.
- **States:** IDLE, READ, MERGE, WRITE, DONE.
- **IDLE:**
  - req=1 at a posedge latches addr, wr, dtype, wdata.
  - Misaligned access goes to DONE with err=1:
    - halfword with addr[0]=1;
    - word (dtype 00/11) with addr[1:0]≠00.
  - Word store: wbuf=wdata, go to WRITE.
  - Otherwise go to READ.
- **READ:** mem_raddr = latched addr[ADDR_WIDTH+1:2]. Go to MERGE; the RAM captures q on this edge.
- **MERGE:**
  - Load: rdata = extracted lane, zero-extended; go to DONE.
  - Store: wbuf = mem_q with the target lane replaced; go to WRITE.
- **WRITE:** mem_we=1, mem_waddr = latched word address, mem_wdata = wbuf. The RAM writes at this cycle's negedge. Go to DONE.
- **DONE:** ack=1 for exactly one cycle, err as determined at IDLE; go to IDLE.
- **Lane mapping (little-endian):**
  - byte k = addr[1:0] occupies bits [8k+7:8k];
  - halfword h = addr[1] occupies bits [16h+15:16h];
  - store lanes take wdata[7:0] for bytes and wdata[15:0] for halfwords.
- **Latency:** counted as the number of posedges after the accepting edge E0, after which ack is high.
  - load: 3 (ack in the cycle after E0+2);
  - sub-word store: 4;
  - word store: 2;
  - misaligned access: 1.
- **Signal defaults:** mem_we is 0 in every state except WRITE. mem_raddr holds its last value outside READ.
- **Requester rule:** the requester drops req in the ack cycle. If req is still high in IDLE it is a new request, accepted on the next edge. Inputs may change freely once the request is accepted.
- **rdata:** unchanged by stores and by errored transactions.
- **Wrap:** the word index is addr[ADDR_WIDTH+1:2]. With no carry between words, the top word behaves like any other.

Test Plan:
1. **Reset, then word store and load.** After reset, store word addr=0x08, wdata=0xDEADBEEF.
   - Required: ack 2 edges after acceptance; mem_we high exactly one cycle with mem_waddr=2.
   - Then load word from 0x08. Required: rdata=0xDEADBEEF, ack after 3 edges.
2. **Byte store RMW.** Word 2 holds 0xDEADBEEF. Store byte addr=0x09, wdata=0x55.
   - Required: word 2 = 0xDEAD55EF.
   - Load byte 0x0A → rdata=0x000000AD. Load half 0x0A → rdata=0x0000DEAD.
3. **Halfword store.** Store half addr=0x0E, wdata=0x1234ABCD to a word holding 0.
   - Required: word 3 = 0xABCD0000; mem_we pulsed once; ack after 4 edges.
4. **Misaligned access.** Load word addr=0x05; store half addr=0x03.
   - Required: ack with err=1 one edge after acceptance; mem_we never high; rdata unchanged.
5. **Reset mid-transaction.** Start a byte store, assert rst_n=0 while in MERGE, then release.
   - Required: no RAM write, no ack; outputs zero during reset.
   - A following load of the target word returns its original value.
6. **Back-to-back requests.** Hold req high across two transactions with different addresses.
   - Required: second transaction accepted on the edge after the DONE cycle; two distinct ack pulses; busy low for exactly the IDLE cycle between them.
